// File: rtl/perf_counter_bank.sv
// Multi-channel performance counter bank: per-channel event select, wrap/saturate,
// sticky overflow and threshold flags, masked group commands and indexed shadow readback.
module perf_counter_bank #(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 32,
  parameter int NUM_EVT = 8,
  localparam int IDX_W  = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
  localparam int EVT_W  = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [NUM_EVT-1:0] events_i,
  input  logic               cmd_we_i,
  input  logic [NUM_CNT-1:0] cmd_mask_i,
  input  logic               cmd_en_i,
  input  logic               cmd_clear_i,
  input  logic               cmd_save_i,
  input  logic               cfg_we_i,
  input  logic [IDX_W-1:0]   cfg_idx_i,
  input  logic [EVT_W-1:0]   cfg_evt_i,
  input  logic               cfg_sat_i,
  input  logic [CNT_W-1:0]   cfg_thr_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic [CNT_W-1:0]   rd_cnt_o,
  output logic               rd_ovf_o,
  output logic               rd_thr_o,
  output logic               irq_o
);

  // Event bus padded to the full select range; selects beyond NUM_EVT see a constant 0.
  localparam int EXT_EVT = 1 << EVT_W;

  logic [EXT_EVT-1:0] evt_ext_s;

  logic [CNT_W-1:0]   cnt_q     [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d     [NUM_CNT];
  logic [CNT_W-1:0]   shadow_q  [NUM_CNT];
  logic [CNT_W-1:0]   shadow_d  [NUM_CNT];
  logic [CNT_W-1:0]   thr_q     [NUM_CNT];
  logic [CNT_W-1:0]   thr_d     [NUM_CNT];
  logic [EVT_W-1:0]   evt_sel_q [NUM_CNT];
  logic [EVT_W-1:0]   evt_sel_d [NUM_CNT];
  logic [CNT_W-1:0]   inc_val_s [NUM_CNT];

  logic [NUM_CNT-1:0] en_q, en_d;
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic [NUM_CNT-1:0] hit_q, hit_d;
  logic [NUM_CNT-1:0] sat_q, sat_d;
  logic [NUM_CNT-1:0] inc_s;
  logic [NUM_CNT-1:0] at_max_s;

  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic               rd_ovf_q, rd_ovf_d;
  logic               rd_thr_q, rd_thr_d;
  logic               irq_q, irq_d;

  // Zero-extend the event bus so any select value indexes a defined bit.
  always_comb begin
    evt_ext_s = '0;
    for (int e = 0; e < NUM_EVT; e++) begin
      evt_ext_s[e] = events_i[e];
    end
  end

  // Per-channel next state: increment, then command (clear wins), then config.
  always_comb begin
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    thr_d     = thr_q;
    evt_sel_d = evt_sel_q;
    en_d      = en_q;
    ovf_d     = ovf_q;
    hit_d     = hit_q;
    sat_d     = sat_q;
    inc_s     = '0;
    at_max_s  = '0;
    for (int c = 0; c < NUM_CNT; c++) begin
      inc_s[c]    = en_q[c] & evt_ext_s[evt_sel_q[c]];
      at_max_s[c] = &cnt_q[c];
      if (at_max_s[c]) begin
        inc_val_s[c] = sat_q[c] ? cnt_q[c] : {CNT_W{1'b0}};
      end else begin
        inc_val_s[c] = cnt_q[c] + CNT_W'(1);
      end

      if (inc_s[c]) begin
        cnt_d[c] = inc_val_s[c];
        if (at_max_s[c]) begin
          ovf_d[c] = 1'b1;
        end else begin
          ovf_d[c] = ovf_q[c];
        end
        // A held saturated value is not a new arrival at the threshold.
        if ((inc_val_s[c] == thr_q[c]) && !(at_max_s[c] && sat_q[c])) begin
          hit_d[c] = 1'b1;
        end else begin
          hit_d[c] = hit_q[c];
        end
      end else begin
        cnt_d[c] = cnt_q[c];
      end

      if (cmd_we_i && cmd_mask_i[c]) begin
        en_d[c] = cmd_en_i;
        if (cmd_save_i) begin
          shadow_d[c] = cnt_q[c];
        end else begin
          shadow_d[c] = shadow_q[c];
        end
        if (cmd_clear_i) begin
          cnt_d[c] = {CNT_W{1'b0}};
          ovf_d[c] = 1'b0;
          hit_d[c] = 1'b0;
        end else begin
          en_d[c] = cmd_en_i;
        end
      end else begin
        en_d[c] = en_q[c];
      end

      if (cfg_we_i && (cfg_idx_i == IDX_W'(c))) begin
        evt_sel_d[c] = cfg_evt_i;
        sat_d[c]     = cfg_sat_i;
        thr_d[c]     = cfg_thr_i;
      end else begin
        evt_sel_d[c] = evt_sel_q[c];
      end
    end
  end

  // Readback mux and interrupt; out-of-range indices match no channel and read zero.
  always_comb begin
    rd_cnt_d = '0;
    rd_ovf_d = 1'b0;
    rd_thr_d = 1'b0;
    for (int c = 0; c < NUM_CNT; c++) begin
      rd_cnt_d = rd_cnt_d | ((rd_idx_i == IDX_W'(c)) ? shadow_q[c] : {CNT_W{1'b0}});
      rd_ovf_d = rd_ovf_d | ((rd_idx_i == IDX_W'(c)) & ovf_q[c]);
      rd_thr_d = rd_thr_d | ((rd_idx_i == IDX_W'(c)) & hit_q[c]);
    end
    irq_d = |hit_q;
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int c = 0; c < NUM_CNT; c++) begin
        cnt_q[c]     <= '0;
        shadow_q[c]  <= '0;
        thr_q[c]     <= '0;
        evt_sel_q[c] <= '0;
      end
      en_q     <= '0;
      ovf_q    <= '0;
      hit_q    <= '0;
      sat_q    <= '0;
      rd_cnt_q <= '0;
      rd_ovf_q <= 1'b0;
      rd_thr_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      thr_q     <= thr_d;
      evt_sel_q <= evt_sel_d;
      en_q      <= en_d;
      ovf_q     <= ovf_d;
      hit_q     <= hit_d;
      sat_q     <= sat_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_ovf_q  <= rd_ovf_d;
      rd_thr_q  <= rd_thr_d;
      irq_q     <= irq_d;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign rd_ovf_o = rd_ovf_q;
  assign rd_thr_o = rd_thr_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench for perf_counter_bank (5 channels, 4-bit counters, 6 events).
module tb_perf_counter_bank;
  localparam int NUM_CNT = 5;
  localparam int CNT_W   = 4;
  localparam int NUM_EVT = 6;
  localparam int IDX_W   = 3;
  localparam int EVT_W   = 3;

  logic               clk = 1'b0;
  logic               reset_ni;
  logic [NUM_EVT-1:0] events_i;
  logic               cmd_we_i;
  logic [NUM_CNT-1:0] cmd_mask_i;
  logic               cmd_en_i;
  logic               cmd_clear_i;
  logic               cmd_save_i;
  logic               cfg_we_i;
  logic [IDX_W-1:0]   cfg_idx_i;
  logic [EVT_W-1:0]   cfg_evt_i;
  logic               cfg_sat_i;
  logic [CNT_W-1:0]   cfg_thr_i;
  logic [IDX_W-1:0]   rd_idx_i;
  logic [CNT_W-1:0]   rd_cnt_o;
  logic               rd_ovf_o;
  logic               rd_thr_o;
  logic               irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  perf_counter_bank #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .NUM_EVT(NUM_EVT)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .events_i(events_i),
    .cmd_we_i(cmd_we_i), .cmd_mask_i(cmd_mask_i), .cmd_en_i(cmd_en_i),
    .cmd_clear_i(cmd_clear_i), .cmd_save_i(cmd_save_i),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_evt_i(cfg_evt_i),
    .cfg_sat_i(cfg_sat_i), .cfg_thr_i(cfg_thr_i), .rd_idx_i(rd_idx_i),
    .rd_cnt_o(rd_cnt_o), .rd_ovf_o(rd_ovf_o), .rd_thr_o(rd_thr_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input int evt, input logic sat, input int thr);
    cfg_we_i  = 1'b1;
    cfg_idx_i = IDX_W'(idx);
    cfg_evt_i = EVT_W'(evt);
    cfg_sat_i = sat;
    cfg_thr_i = CNT_W'(thr);
    tick();
    cfg_we_i  = 1'b0;
  endtask

  task automatic cmd(input logic [NUM_CNT-1:0] mask, input logic en, input logic clr, input logic sv);
    cmd_we_i    = 1'b1;
    cmd_mask_i  = mask;
    cmd_en_i    = en;
    cmd_clear_i = clr;
    cmd_save_i  = sv;
    tick();
    cmd_we_i    = 1'b0;
    cmd_clear_i = 1'b0;
    cmd_save_i  = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_EVT-1:0] ev, input int n);
    for (int i = 0; i < n; i++) begin
      events_i = ev;
      tick();
    end
    events_i = '0;
  endtask

  task automatic rd(input int idx);
    rd_idx_i = IDX_W'(idx);
    tick();
  endtask

  initial begin
    reset_ni = 1'b0; events_i = '0; cmd_we_i = 1'b0; cmd_mask_i = '0; cmd_en_i = 1'b0;
    cmd_clear_i = 1'b0; cmd_save_i = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = '0;
    cfg_evt_i = '0; cfg_sat_i = 1'b0; cfg_thr_i = '0; rd_idx_i = '0;
    repeat (2) tick();
    check_val("rst_cnt", 32'(rd_cnt_o), 32'd0);
    check_val("rst_irq", 32'(irq_o), 32'd0);
    reset_ni = 1'b1;
    tick();
    check_val("post_rst_ovf", 32'(rd_ovf_o), 32'd0);

    // Basic count of 5 on ch0, event 2
    cfg(0, 2, 1'b0, 0);
    cmd(5'b00001, 1'b1, 1'b0, 1'b0);
    pulse(6'b000100, 5);
    cmd(5'b00001, 1'b1, 1'b0, 1'b1);
    rd(0);
    check_val("t1_cnt", 32'(rd_cnt_o), 32'd5);
    check_val("t1_ovf", 32'(rd_ovf_o), 32'd0);
    for (int c = 1; c < NUM_CNT; c++) begin
      rd(c);
      check_val("t1_other", 32'(rd_cnt_o), 32'd0);
    end

    // Event coinciding with the enabling command is not counted
    cfg(3, 5, 1'b0, 0);
    events_i = 6'b100000;
    cmd(5'b01000, 1'b1, 1'b0, 1'b0);
    events_i = '0;
    cmd(5'b01000, 1'b1, 1'b0, 1'b1);
    rd(3);
    check_val("en_same_cycle", 32'(rd_cnt_o), 32'd0);

    // Saturate: 17 events hold 15 with overflow, no threshold hit at thr=0
    cfg(1, 1, 1'b1, 0);
    cmd(5'b00010, 1'b1, 1'b0, 1'b0);
    pulse(6'b000010, 17);
    cmd(5'b00010, 1'b1, 1'b0, 1'b1);
    rd(1);
    check_val("sat_cnt", 32'(rd_cnt_o), 32'd15);
    check_val("sat_ovf", 32'(rd_ovf_o), 32'd1);
    check_val("sat_thr", 32'(rd_thr_o), 32'd0);

    // Wrap: 17 events give 1 with overflow; wrap to 0 hits thr=0
    cmd(5'b00010, 1'b1, 1'b1, 1'b0);
    cfg(1, 1, 1'b0, 0);
    pulse(6'b000010, 17);
    cmd(5'b00010, 1'b1, 1'b0, 1'b1);
    rd(1);
    check_val("wrap_cnt", 32'(rd_cnt_o), 32'd1);
    check_val("wrap_ovf", 32'(rd_ovf_o), 32'd1);
    check_val("wrap_thr", 32'(rd_thr_o), 32'd1);
    check_val("wrap_irq", 32'(irq_o), 32'd1);
    cmd(5'b00010, 1'b0, 1'b1, 1'b0);
    tick();
    check_val("wrap_irq_clr", 32'(irq_o), 32'd0);

    // Threshold 3 on ch2 and irq timing
    cfg(2, 3, 1'b0, 3);
    cmd(5'b00100, 1'b1, 1'b0, 1'b0);
    pulse(6'b001000, 2);
    check_val("thr_irq_pre", 32'(irq_o), 32'd0);
    pulse(6'b001000, 1);
    check_val("thr_irq_edge", 32'(irq_o), 32'd0);
    tick();
    check_val("thr_irq_set", 32'(irq_o), 32'd1);
    cmd(5'b00100, 1'b1, 1'b0, 1'b1);
    rd(2);
    check_val("thr_cnt", 32'(rd_cnt_o), 32'd3);
    check_val("thr_flag", 32'(rd_thr_o), 32'd1);
    cmd(5'b00100, 1'b0, 1'b1, 1'b0);
    check_val("thr_irq_hold", 32'(irq_o), 32'd1);
    tick();
    check_val("thr_irq_drop", 32'(irq_o), 32'd0);
    cmd(5'b00100, 1'b0, 1'b0, 1'b1);
    rd(2);
    check_val("thr_cnt_clr", 32'(rd_cnt_o), 32'd0);
    check_val("thr_flag_clr", 32'(rd_thr_o), 32'd0);

    // Clear+save while all increment at 7; ch3 would hit thr=8 but clear wins
    for (int c = 0; c < NUM_CNT; c++) cfg(c, 4, 1'b0, (c == 3) ? 8 : 0);
    cmd(5'b11111, 1'b1, 1'b1, 1'b0);
    pulse(6'b010000, 7);
    events_i = 6'b010000;
    cmd(5'b11111, 1'b1, 1'b1, 1'b1);
    events_i = '0;
    for (int c = 0; c < NUM_CNT; c++) begin
      rd(c);
      check_val("cs_shadow", 32'(rd_cnt_o), 32'd7);
      check_val("cs_ovf", 32'(rd_ovf_o), 32'd0);
      check_val("cs_thr", 32'(rd_thr_o), 32'd0);
    end
    cmd(5'b11111, 1'b1, 1'b0, 1'b1);
    rd(3);
    check_val("cs_cnt_zero", 32'(rd_cnt_o), 32'd0);

    // Masked group save; out-of-range cfg and read indices
    cfg(0, 0, 1'b0, 0);
    cfg(1, 1, 1'b0, 0);
    cfg(3, 3, 1'b0, 4);
    cfg(4, 6, 1'b0, 0);
    cfg(5, 7, 1'b1, 2);
    for (int i = 0; i < 9; i++) begin
      events_i = 6'b000010 | ((i < 4) ? 6'b001000 : 6'b000000) | ((i < 6) ? 6'b000001 : 6'b000000);
      tick();
    end
    events_i = '0;
    cmd(5'b01010, 1'b1, 1'b0, 1'b1);
    rd(1);
    check_val("gs_ch1", 32'(rd_cnt_o), 32'd9);
    rd(3);
    check_val("gs_ch3", 32'(rd_cnt_o), 32'd4);
    check_val("gs_ch3_thr", 32'(rd_thr_o), 32'd1);
    rd(0);
    check_val("gs_ch0", 32'(rd_cnt_o), 32'd0);
    rd(5);
    check_val("oor5_cnt", 32'(rd_cnt_o), 32'd0);
    check_val("oor5_thr", 32'(rd_thr_o), 32'd0);
    rd(7);
    check_val("oor7_cnt", 32'(rd_cnt_o), 32'd0);
    pulse(6'b111111, 3);
    cmd(5'b10000, 1'b1, 1'b0, 1'b1);
    rd(4);
    check_val("bad_evt", 32'(rd_cnt_o), 32'd0);

    // Asynchronous reset mid-count
    rd(1);
    check_val("pre_rst_cnt", 32'(rd_cnt_o), 32'd9);
    check_val("pre_rst_irq", 32'(irq_o), 32'd1);
    events_i = 6'b111111;
    #2 reset_ni = 1'b0;
    #1;
    check_val("arst_cnt", 32'(rd_cnt_o), 32'd0);
    check_val("arst_irq", 32'(irq_o), 32'd0);
    @(negedge clk);
    reset_ni = 1'b1;
    pulse(6'b111111, 3);
    cmd(5'b11111, 1'b0, 1'b0, 1'b1);
    rd(1);
    check_val("after_rst_ch1", 32'(rd_cnt_o), 32'd0);
    rd(0);
    check_val("after_rst_ch0", 32'(rd_cnt_o), 32'd0);
    check_val("after_rst_irq", 32'(irq_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
